// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronized serial line, mid-bit sampling FSM and a one-entry holding register.
// Defining UART_RX_PARITY_EN adds one even-parity bit between the data bits and the stop bit.
module uart_receiver #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 serial_data_in,
  input  logic                 read_data,
  output logic [DATA_SIZE-1:0] bus_data_out,
  output logic                 rx_full,
  output logic [7:0]           RX_status_register
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_SIZE);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;
  logic                 stp_q, stp_d;
  logic                 brk_q, brk_d;
  logic                 par_err;
  logic                 frame_done, good_stop, load;
  logic                 fall, tick_half, tick_full, line;

  assign line      = sync2_q;
  assign fall      = prev_q & ~sync2_q;
  assign tick_half = (cnt_q == HALF_LAST);
  assign tick_full = (cnt_q == FULL_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic par_err_q, par_err_d;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    good_stop  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_half) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = line ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_full) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[DATA_SIZE-1:1]};
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_full) begin
          cnt_d     = '0;
          par_bit_d = line;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_full) begin
          cnt_d      = '0;
          frame_done = 1'b1;
          good_stop  = line;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new event in the same cycle as read_data survives the clear.
  always_comb begin
    load   = frame_done & good_stop;
    data_d = data_q;
    full_d = full_q;
    if (load && (!full_q || read_data)) data_d = shift_q;
    if (load)           full_d = 1'b1;
    else if (read_data) full_d = 1'b0;
    ovf_d = (load & full_q & ~read_data) | (ovf_q & ~read_data);
    stp_d = (frame_done & ~good_stop & (|shift_q)) | (stp_q & ~read_data);
    brk_d = (frame_done & ~good_stop & ~(|shift_q)) | (brk_q & ~read_data);
`ifdef UART_RX_PARITY_EN
    par_err_d = (load & (par_bit_q != ^shift_q)) | (par_err_q & ~read_data);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      stp_q     <= 1'b0;
      brk_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      sync1_q   <= serial_data_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      stp_q     <= stp_d;
      brk_q     <= brk_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign bus_data_out       = data_q;
  assign rx_full            = full_q;
  assign RX_status_register = {3'b000, ovf_q, stp_q, brk_q, par_err, full_q};

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, meaning data bits per frame (range 5..9).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (even, at least 4).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port serial_data_in, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port read_data, input, 1 bit: host pop strobe for the holding register, one cycle.
REQ-007 The block SHALL have port bus_data_out, output, DATA_SIZE bits: holding register, LSB = first received bit.
REQ-008 The block SHALL have port rx_full, output, 1 bit: holding register contains unread data.
REQ-009 The block SHALL have port RX_status_register, output, 8 bits: {3'b0, overflow_error, stop_error, break_error, parity_error, rx_full}.

Function
REQ-010 serial_data_in SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-011 The FSM SHALL have the states IDLE, START, DATA, PARITY, and STOP, with a bit-time counter and a bit index.
REQ-012 In IDLE, a synchronized 1->0 transition SHALL enter START with the counter cleared.
REQ-013 In START, after CLKS_PER_BIT/2 cycles the line SHALL be sampled: low -> DATA; high -> IDLE (glitch, no flags set).
REQ-014 In DATA, the line SHALL be sampled every CLKS_PER_BIT cycles (mid-bit), DATA_SIZE samples, LSB first, into a shift register.
REQ-015 After the last data bit, the FSM SHALL go to PARITY if UART_RX_PARITY_EN is defined, else to STOP.
REQ-016 In STOP, one sample SHALL be taken CLKS_PER_BIT cycles after the previous sample; the FSM SHALL then return to IDLE on the next cycle.
REQ-017 A stop sample of 1 SHALL be a good frame.
REQ-018 A stop sample of 0 with all data bits 0 SHALL set break_error, with no load.
REQ-019 A stop sample of 0 with any data bit 1 SHALL set stop_error, with no load.
REQ-020 A good frame SHALL load bus_data_out and set rx_full on the cycle after the stop sample (latency 1).
REQ-021 If a load occurs while rx_full=1 and read_data=0, the SHALL set overflow_error, discard the new data, and keep the old data.
REQ-022 read_data with rx_full=1 SHALL clear rx_full next cycle; read_data with rx_full=0 SHALL have no effect on data.
REQ-023 On a simultaneous load and read_data, the new data SHALL be loaded, rx_full SHALL remain 1, and no overflow SHALL occur.
REQ-024 Error flags SHALL be sticky and cleared together by any read_data pulse; a set event in the same cycle as read_data SHALL win.
REQ-025 Return to IDLE after a stop_error or break_error SHALL require a new 1->0 edge, so a held-low line produces no further frames.

Reset
REQ-026 On reset_n=0, the FSM SHALL enter IDLE and the counters, the shift register, bus_data_out, rx_full, and all error flags SHALL clear to 0.
REQ-027 On reset_n=0, the synchronizer flops SHALL reset to 1 (idle line).
REQ-028 Reset asserted mid-frame SHALL abandon the frame without loading data or setting flags.
REQ-029 After reset release, the first frame SHALL be accepted only from a fresh falling edge.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, one even-parity bit SHALL follow the data; it SHALL be sampled in PARITY one bit-time after the last data bit.
REQ-031 With UART_RX_PARITY_EN defined, a parity mismatch on a good-stop frame SHALL still load the data and SHALL set parity_error.
REQ-032 Without UART_RX_PARITY_EN, the frame SHALL be start + DATA_SIZE + stop, the PARITY state SHALL be absent, and parity_error SHALL be constant 0.

Verification
REQ-033 Scenario, 8N1 good frame: frame 0xA5, CLKS_PER_BIT=16 -> bus_data_out=0xA5, rx_full=1, RX_status_register=0x01.
REQ-034 Scenario, start glitch: low pulse of 4 cycles -> FSM back in IDLE, no load, status=0x00.
REQ-035 Scenario, overflow: frames 0x3C then 0x81 with no read -> bus_data_out=0x3C, status=0x11; then read_data -> status=0x00.
REQ-036 Scenario, break: line held low for 12 bit-times -> break_error=1 (status=0x04), exactly one event, no load.
REQ-037 Scenario, stop error and load/read collision: frame 0x55 with stop=0 -> stop_error=1, no load; read_data in the load cycle of a second frame 0x0F while holding 0x3C -> bus_data_out=0x0F, rx_full=1, overflow_error=0.
REQ-038 Scenario, parity (UART_RX_PARITY_EN defined): frame 0x07 with parity bit 0 -> data loaded, status=0x03; reset_n pulse mid-DATA -> status=0x00, no load.
